// File: rtl/jtag_master.sv
// JTAG host engine: turns TAP_RESET/SHIFT_IR/SHIFT_DR/IDLE commands into TMS/TDI/TCK sequences from and back to Run-Test/Idle.
// Response at 1 + N*2*CLKDIV cycles after acceptance (1 for rejects); one command in flight, RSP held until rsp_ready.
module jtag_master #(
   parameter int DR_MAX = 64,
   parameter int CLKDIV = 2
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [6:0]        cmd_len,
   input  logic [DR_MAX-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DR_MAX-1:0] rsp_data,
   output logic              rsp_err,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   output logic              trst,
   input  logic              tdo
);
   localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_IR    = 2'b01;
   localparam logic [1:0] OP_DR    = 2'b10;
   localparam logic [1:0] OP_IDLE  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RUN, S_RSP} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_up;
   logic [1:0]         r_op;
   logic [6:0]         r_len;
   logic [6:0]         r_cnt;
   logic [5:0]         r_hdr;
   logic [DR_MAX-1:0]  r_sreg;
   logic [DIV_W-1:0]   r_div;
   logic               r_tck;
   logic               r_tms;
   logic               r_tdi;
   logic               r_trst;
   logic               r_synced;
   logic               r_rsp_valid;
   logic [DR_MAX-1:0]  r_rsp_data;
   logic               r_rsp_err;

   logic w_cmd_ready, w_accept, w_bad, w_immed, w_active, w_pend, w_rise, w_fall, w_last;

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = (r_state == S_IDLE) && r_up;
      w_accept    = cmd_valid && w_cmd_ready;
      w_bad       = (cmd_op != OP_RESET) &&
                    (!r_synced || (32'(cmd_len) > DR_MAX) ||
                     ((cmd_op != OP_IDLE) && (cmd_len == 7'd0)));
      w_immed     = w_bad || ((cmd_op == OP_IDLE) && (cmd_len == 7'd0));
      w_active    = (r_state inside {S_HDR, S_SHIFT, S_TRL, S_RUN});
      w_pend      = (r_div == DIV_W'(CLKDIV - 1));
      w_rise      = w_active && w_pend && !r_tck;
      w_fall      = w_active && w_pend && r_tck;
      w_last      = (r_cnt == 7'd1);
      case (r_state)
         S_IDLE:
            if (w_accept) begin
               if (w_immed)                w_state_nxt = S_RSP;
               else if (cmd_op == OP_IDLE) w_state_nxt = S_RUN;
               else                        w_state_nxt = S_HDR;
            end
         S_HDR:   if (w_fall && w_last) w_state_nxt = (r_op == OP_RESET) ? S_RSP : S_SHIFT;
         S_SHIFT: if (w_fall && w_last) w_state_nxt = S_TRL;
         S_TRL:   if (w_fall && w_last) w_state_nxt = S_RSP;
         S_RUN:   if (w_fall && w_last) w_state_nxt = S_RSP;
         S_RSP:   if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_up        <= 1'b0;
         r_op        <= OP_RESET;
         r_len       <= 7'd0;
         r_cnt       <= 7'd0;
         r_hdr       <= 6'd0;
         r_sreg      <= '0;
         r_div       <= '0;
         r_tck       <= 1'b0;
         r_tms       <= 1'b1;
         r_tdi       <= 1'b0;
         r_trst      <= 1'b0;
         r_synced    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_up <= 1'b1;
         if (w_active) begin
            if (w_pend) begin
               r_div <= '0;
               r_tck <= ~r_tck;
            end else begin
               r_div <= r_div + 1'b1;
            end
         end
         case (r_state)
            S_IDLE: begin
               r_trst <= 1'b1;
               if (w_accept) begin
                  r_op   <= cmd_op;
                  r_len  <= cmd_len;
                  r_sreg <= cmd_data;
                  r_div  <= '0;
                  r_tck  <= 1'b0;
                  if (w_immed) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= w_bad;
                     r_rsp_data  <= '0;
                  end else begin
                     // header TMS patterns are stored LSB-first
                     case (cmd_op)
                        OP_RESET: begin r_hdr <= 6'b011111; r_cnt <= 7'd6; r_tms <= 1'b1; r_trst <= 1'b0; end
                        OP_IR:    begin r_hdr <= 6'b000011; r_cnt <= 7'd4; r_tms <= 1'b1; end
                        OP_DR:    begin r_hdr <= 6'b000001; r_cnt <= 7'd3; r_tms <= 1'b1; end
                        default:  begin r_cnt <= cmd_len;   r_tms <= 1'b0; end
                     endcase
                  end
               end
            end
            S_HDR:
               if (w_fall) begin
                  if (w_last) begin
                     if (r_op == OP_RESET) begin
                        r_synced    <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= '0;
                     end else begin
                        r_cnt <= r_len;
                        r_tms <= (r_len == 7'd1);
                        r_tdi <= r_sreg[0];
                     end
                  end else begin
                     r_hdr <= r_hdr >> 1;
                     r_tms <= r_hdr[1];
                     r_cnt <= r_cnt - 7'd1;
                     if (r_cnt == 7'd2) r_trst <= 1'b1;
                  end
               end
            S_SHIFT:
               if (w_rise) begin
                  r_sreg <= {tdo, r_sreg[DR_MAX-1:1]};
               end else if (w_fall) begin
                  if (w_last) begin
                     r_tms <= 1'b1;
                     r_tdi <= 1'b0;
                     r_hdr <= 6'b000001;
                     r_cnt <= 7'd2;
                  end else begin
                     r_cnt <= r_cnt - 7'd1;
                     r_tms <= (r_cnt == 7'd2);
                     r_tdi <= r_sreg[0];
                  end
               end
            S_TRL:
               if (w_fall) begin
                  if (w_last) begin
                     // captured bits sit at the top of the register; right-justify them
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_rsp_data  <= r_sreg >> (DR_MAX - 32'(r_len));
                  end else begin
                     r_hdr <= r_hdr >> 1;
                     r_tms <= r_hdr[1];
                     r_cnt <= r_cnt - 7'd1;
                  end
               end
            S_RUN:
               if (w_fall) begin
                  if (w_last) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_rsp_data  <= '0;
                  end else begin
                     r_cnt <= r_cnt - 7'd1;
                  end
               end
            S_RSP:
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_data  <= '0;
               end
            default: ;
         endcase
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign tck       = r_tck;
   assign tms       = r_tms;
   assign tdi       = r_tdi;
   assign trst      = r_trst;
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP device plus a command-level reference model with random traffic.
module tb_jtag_master;
   localparam int DR_MAX = 64;
   localparam int CLKDIV = 2;
   localparam int LOGN   = 16384;
   localparam logic [31:0] IDCODE_VAL = 32'h4BA0_0477;
   localparam logic [3:0]  IR_IDCODE  = 4'h1;
   localparam logic [3:0]  IR_BYPASS  = 4'hF;
   localparam logic [1:0]  OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11;
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                  UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

   logic sys_clk = 1'b0;
   logic reset = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [1:0] cmd_op = 2'b00;
   logic [6:0] cmd_len = 7'd0;
   logic [DR_MAX-1:0] cmd_data = '0, rsp_data;
   logic tck, tms, tdi, trst, tdo;

   int n_chk = 0, n_pass = 0;
   logic m_synced = 1'b0;
   logic [3:0] m_ir = IR_IDCODE;

   always #5 sys_clk = ~sys_clk;

   jtag_master #(.DR_MAX(DR_MAX), .CLKDIV(CLKDIV)) dut (
      .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .tck(tck), .tms(tms),
      .tdi(tdi), .trst(trst), .tdo(tdo));

   // IEEE 1149.1 TAP device: 4-bit IR, 32-bit IDCODE DR, everything else is BYPASS
   int tap_st = TLR;
   logic [3:0] tap_ir = IR_IDCODE, tap_irs = 4'h0;
   logic [63:0] tap_drs = '0;

   function automatic int tap_next(input int s, input logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PADR;
         PADR:  return m ? EX2DR : PADR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAIR;
         PAIR:  return m ? EX2IR : PAIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge tck or negedge trst) begin
      if (!trst) begin
         tap_st <= TLR;
         tap_ir <= IR_IDCODE;
      end else begin
         case (tap_st)
            TLR:   tap_ir  <= IR_IDCODE;
            CAPDR: tap_drs <= (tap_ir == IR_IDCODE) ? {32'b0, IDCODE_VAL} : 64'b0;
            SHDR:  tap_drs <= (tap_ir == IR_IDCODE) ? {32'b0, tdi, tap_drs[31:1]} : {63'b0, tdi};
            CAPIR: tap_irs <= 4'b0001;
            SHIR:  tap_irs <= {tdi, tap_irs[3:1]};
            UPIR:  tap_ir  <= tap_irs;
            default: ;
         endcase
         tap_st <= tap_next(tap_st, tms);
      end
   end

   always @(negedge tck or negedge trst) begin
      if (!trst)               tdo <= 1'b0;
      else if (tap_st == SHDR) tdo <= tap_drs[0];
      else if (tap_st == SHIR) tdo <= tap_irs[0];
      else                     tdo <= 1'b0;
   end

   // pin log sampled on every TCK rise
   int tck_cnt = 0;
   logic tms_log [LOGN];
   logic tdi_log [LOGN];
   logic trst_log [LOGN];
   always @(posedge tck) begin
      tms_log[tck_cnt % LOGN]  = tms;
      tdi_log[tck_cnt % LOGN]  = tdi;
      trst_log[tck_cnt % LOGN] = trst;
      tck_cnt = tck_cnt + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   // bits [from, from+n) of the TDO stream: the captured register value c (L bits) followed by the TDI data d
   function automatic logic [63:0] stream(input int L, input logic [63:0] c, input logic [63:0] d,
                                          input int from, input int n);
      logic [63:0] r;
      int i;
      r = '0;
      for (int k = 0; k < n; k++) begin
         i = from + k;
         if (i < L) r[k] = c[i];
         else       r[k] = d[i-L];
      end
      return r;
   endfunction

   task automatic run_cmd(input logic [1:0] op, input int len, input logic [63:0] data,
                          output logic [63:0] got, output int lat);
      logic bad;
      int n_tck, hdr, L, t0, cyc, lim, w, trst_lo;
      logic [63:0] e_data, c_val, tmp;
      logic [127:0] e_tms, e_tdi, o_tms, o_tdi;
      bad = (op != OP_RESET) && (!m_synced || len > DR_MAX || (op != OP_IDLE && len == 0));
      e_tms = '0; e_tdi = '0; e_data = '0; c_val = '0; n_tck = 0; hdr = 0; L = 0;
      if (!bad) begin
         case (op)
            OP_RESET: begin n_tck = 6; e_tms = 128'h1F; end
            OP_IR:    begin hdr = 4; e_tms = 128'h3; L = 4; c_val = 64'h1; end
            OP_DR: begin
               hdr = 3; e_tms = 128'h1;
               if (m_ir == IR_IDCODE) begin L = 32; c_val = {32'b0, IDCODE_VAL}; end
               else begin L = 1; c_val = '0; end
            end
            default: n_tck = len;
         endcase
         if (op == OP_IR || op == OP_DR) begin
            n_tck = hdr + len + 2;
            e_tms[hdr+len-1] = 1'b1;
            e_tms[hdr+len]   = 1'b1;
            for (int i = 0; i < len; i++) e_tdi[hdr+i] = data[i];
            e_data = stream(L, c_val, data, 0, len);
         end
      end
      @(negedge sys_clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_len = 7'(len); cmd_data = data;
      w = 0;
      while (!cmd_ready && w < 50) begin @(negedge sys_clk); w++; end
      if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
      t0 = tck_cnt;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      cmd_data = {$urandom, $urandom};
      cyc = 1;
      chk("busy_not_ready", cmd_ready, 0);
      lim = 1 + n_tck * 2 * CLKDIV + 20;
      while (!rsp_valid && cyc < lim) begin @(negedge sys_clk); cyc++; end
      lat = cyc;
      got = rsp_data;
      chk("latency", cyc, 1 + n_tck * 2 * CLKDIV);
      chk("rsp_err", rsp_err, bad);
      chk("rsp_data", rsp_data, e_data);
      chk("tck_count", tck_cnt - t0, n_tck);
      o_tms = '0; o_tdi = '0; trst_lo = 0;
      for (int k = 0; k < n_tck && k < 128; k++) begin
         o_tms[k] = tms_log[(t0 + k) % LOGN];
         o_tdi[k] = tdi_log[(t0 + k) % LOGN];
         if (!trst_log[(t0 + k) % LOGN]) trst_lo++;
      end
      chk("tms_seq", o_tms, e_tms);
      chk("tdi_seq", o_tdi, e_tdi);
      chk("trst_low_periods", trst_lo, (op == OP_RESET && !bad) ? 5 : 0);
      w = $urandom_range(0, 2);
      repeat (w) @(negedge sys_clk);
      chk("rsp_hold", {rsp_valid, rsp_err, rsp_data}, {1'b1, bad, e_data});
      rsp_ready = 1'b1;
      @(negedge sys_clk);
      rsp_ready = 1'b0;
      chk("rsp_one_cycle", rsp_valid, 0);
      chk("ready_after_rsp", cmd_ready, 1);
      chk("tck_low_between", tck, 0);
      if (!bad) begin
         if (op == OP_RESET) begin m_synced = 1'b1; m_ir = IR_IDCODE; end
         if (op == OP_IR) begin tmp = stream(4, c_val, data, len, 4); m_ir = tmp[3:0]; end
         chk("tap_in_rti", tap_st, RTI);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got, d;
      int lat, t0, n, len, sel;
      logic [1:0] op;
      #1 reset = 1'b1;
      #2;
      chk("rst_outputs", {tck, tms, tdi, trst, cmd_ready, rsp_valid, rsp_err}, 7'b0100000);
      chk("rst_rsp_data", rsp_data, 0);
      repeat (2) @(negedge sys_clk);
      reset = 1'b0;
      @(negedge sys_clk);
      chk("post_rst_trst_ready", {trst, cmd_ready}, 2'b11);

      run_cmd(OP_DR, 8, 64'hA5, got, lat);
      chk("unsynced_lat1", lat, 1);
      run_cmd(OP_RESET, 0, 64'h0, got, lat);
      chk("tap_reset_lat25", lat, 25);
      run_cmd(OP_IR, 4, {60'b0, IR_BYPASS}, got, lat);
      chk("ir_capture_01", got, 64'h1);
      run_cmd(OP_DR, 8, 64'hA5, got, lat);
      chk("bypass_a5_4a", got, 64'h4A);
      chk("bypass_lat53", lat, 53);
      run_cmd(OP_IR, 4, {60'b0, IR_IDCODE}, got, lat);
      run_cmd(OP_DR, 32, 64'h0, got, lat);
      chk("idcode_read", got, {32'b0, IDCODE_VAL});
      run_cmd(OP_IDLE, 0, 64'h0, got, lat);
      chk("idle0_lat1", lat, 1);
      run_cmd(OP_IDLE, 5, 64'h0, got, lat);
      run_cmd(OP_DR, 65, {$urandom, $urandom}, got, lat);
      run_cmd(OP_IR, 0, 64'hF, got, lat);
      run_cmd(OP_IDLE, 65, 64'h0, got, lat);
      run_cmd(OP_DR, 64, {$urandom, $urandom}, got, lat);
      run_cmd(OP_DR, 1, 64'h1, got, lat);

      // reset while bit 3 of a DR shift is on the wire
      @(negedge sys_clk);
      cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = 7'd16; cmd_data = 64'hBEEF;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge sys_clk); n++; end
      t0 = tck_cnt;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      n = 0;
      while (tck_cnt < t0 + 7 && n < 200) begin @(negedge sys_clk); n++; end
      chk("mid_shift_progress", tck_cnt - t0, 7);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_pins", {tck, tms, tdi, trst}, 4'b0100);
      chk("async_rst_handshake", {cmd_ready, rsp_valid, rsp_err}, 3'b000);
      @(negedge sys_clk);
      reset = 1'b0;
      m_synced = 1'b0;
      m_ir = IR_IDCODE;
      @(negedge sys_clk);
      chk("post_rst2_trst_ready", {trst, cmd_ready}, 2'b11);
      run_cmd(OP_DR, 8, 64'h3C, got, lat);
      chk("unsynced_again_err_lat", lat, 1);
      run_cmd(OP_RESET, 0, 64'h0, got, lat);
      run_cmd(OP_DR, 32, {$urandom, $urandom}, got, lat);
      chk("idcode_after_resync", got, {32'b0, IDCODE_VAL});

      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         op = (sel == 0) ? OP_RESET : (sel < 4) ? OP_IR : (sel < 8) ? OP_DR : OP_IDLE;
         sel = $urandom_range(0, 7);
         len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(65, 127) : (sel == 2) ? 64 : $urandom_range(1, 40);
         d = {$urandom, $urandom};
         if (op == OP_IR && $urandom_range(0, 1) == 1) begin
            len = 4;
            d = ($urandom_range(0, 1) == 1) ? {60'b0, IR_IDCODE} : {60'b0, IR_BYPASS};
         end
         run_cmd(op, len, d, got, lat);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/jtag_master.md
# jtag_master

Sys_clk-domain JTAG host engine that drives `tck`/`tms`/`tdi`/`trst` into `jtag_test_logic` and captures its `tdo`. It turns single-beat commands (TAP reset, IR shift, DR shift, idle clocks) into bit-exact TMS/TDI sequences, starting from and returning to Run-Test/Idle. Every shift command returns a response word holding the captured TDO bits. It is the on-chip or FPGA-side front end for boundary-scan and halt/step/resume debug access.

## Interface
Parameters:
- `DR_MAX`, 64: maximum shift length in bits; sets the `cmd_data`/`rsp_data` width.
- `CLKDIV`, 2: sys_clk cycles per TCK half-period; must be ≥1.

Ports:
- `sys_clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high in the same cycle as `cmd_valid`.
- `cmd_op` in 2: 00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE.
- `cmd_len` in 7: bit count for shifts, or TCK count for IDLE.
- `cmd_data` in DR_MAX: TDI bits, LSB shifted first.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when high in the same cycle as `rsp_valid`.
- `rsp_data` out DR_MAX: captured TDO bits; bit 0 is the first bit captured; bits at index ≥ len are 0.
- `rsp_err` out 1: the command was rejected and no TCK was issued; valid with `rsp_valid`.
- `tck`, `tms`, `tdi`, `trst` out 1: JTAG pins to the TAP. `trst` is active-low.
- `tdo` in 1: TAP output.

## Operation
- States: IDLE, HDR (TMS header), SHIFT, TRL (TMS trailer), RUN (idle clocks), RSP.
- IDLE: `cmd_ready`=1. A command is accepted on `cmd_valid`&`cmd_ready`; `cmd_data` is latched into the shift register and `cmd_len` into the bit counter.
- TMS sequences (all start and end in Run-Test/Idle):
  - TAP_RESET: TMS 1,1,1,1,1,0 (6 TCK). `trst`=0 during the first 5 TCK periods. Sets the `synced` flag.
  - SHIFT_DR: header 1,0,0, then len bits with TMS=0 except the last bit (TMS=1), then trailer 1,0. Total 5+len TCK.
  - SHIFT_IR: header 1,1,0,0, the same shift, trailer 1,0. Total 6+len TCK.
  - IDLE: len TCK with TMS=0. len=0 issues no TCK.
- TDI equals shift-register bit 0 during SHIFT and 0 elsewhere.
- Each SHIFT bit captures `tdo` into the shift register from the top. At the end, the register is right-justified by DR_MAX−len so that `rsp_data[len-1:0]` holds the captured bits.
- Rejections (`rsp_err`=1, `rsp_data`=0, no TCK):
  - shift with len=0;
  - shift with len>DR_MAX;
  - IDLE with len>DR_MAX;
  - any SHIFT or IDLE while `synced`=0.
- Every command, including TAP_RESET and IDLE, produces exactly one response.
- RSP: hold `rsp_valid`/`rsp_data`/`rsp_err` until `rsp_ready`, then return to IDLE. `cmd_ready`=0 outside IDLE.

## Timing
- Reset values: `tck`=0, `tms`=1, `tdi`=0, `trst`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `synced`=0, state IDLE.
- On the first cycle after reset deasserts: `trst`=1 and `cmd_ready`=1.
- TCK period = 2·CLKDIV sys_clk cycles; low phase first.
- `tms`/`tdi` change only on the sys_clk edge that drives `tck` 1→0, or on the first low-phase cycle.
- `tdo` is sampled on the sys_clk edge that drives `tck` 0→1.
- Latency: command accepted at cycle 0 → first TCK low phase begins at cycle 1 → `rsp_valid` rises at cycle 1 + N·2·CLKDIV, where N is the TCK count. A rejected command gives `rsp_valid` at cycle 1.
- Back-to-back: the next command can be accepted in the cycle after the `rsp_valid`&`rsp_ready` handshake. `tck` stays low between commands.
- Reset mid-operation: abort immediately, all outputs go to their reset values, and `synced` is cleared. The TAP state is unknown until the next TAP_RESET.
- `rsp_ready` held high: RSP lasts exactly 1 cycle.

## Test plan
- Reset, then SHIFT_DR len 8 before any TAP_RESET → `rsp_err`=1, `rsp_data`=0, no `tck` edges, `rsp_valid` at cycle 1.
- TAP_RESET with CLKDIV=2 → `tms` sequence 1,1,1,1,1,0 on rising TCK; `trst` low for the first 5 periods; `rsp_valid` at cycle 25; `rsp_err`=0.
- After TAP_RESET, SHIFT_DR len 8 with data 0xA5 and BYPASS selected (1-bit bypass captures 0) → `rsp_data`=0x4A; 13 TCK periods; `rsp_valid` at cycle 53.
- SHIFT_IR with len=IR length and the IDCODE opcode, then SHIFT_DR len 32 with data 0 → `rsp_data` equals the device ID with bit 0 = 1; a TMS trace checker confirms the TAP ends in Run-Test/Idle.
- IDLE len 0 → `rsp_valid` at cycle 1, no TCK. SHIFT_DR len 65 with DR_MAX=64 → `rsp_err`=1.
- Assert `reset` during bit 3 of a SHIFT_DR → `tck`=0 and `tms`=1 within 0 cycles (async); a subsequent SHIFT → `rsp_err`; after TAP_RESET, SHIFT succeeds.
